// File: rtl/fir_out_requant.sv
// Requantises the FIR's 32-bit signed stream to 16-bit signed samples (round half up, shift, saturate)
// behind a 2-entry skid buffer, with sticky saturation flag and saturating event counter.
//
//   state | meaning
//   EMPTY | no beat held, m_axis_tvalid low
//   ONE   | head holds one beat, input may still be accepted
//   TWO   | head and tail full, input stalled
module fir_out_requant #(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 16,
  parameter int SHIFT     = 15,
  parameter int SAT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 power_enable,
  input  logic [IN_W-1:0]      s_axis_tdata,
  input  logic [3:0]           s_axis_tkeep,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [OUT_W-1:0]     m_axis_tdata,
  output logic [1:0]           m_axis_tkeep,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  input  logic                 sat_clear,
  output logic                 sat_flag,
  output logic [SAT_CNT_W-1:0] sat_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  localparam int EW    = OUT_W + 3;
  localparam int MAX_I = (1 << (OUT_W - 1)) - 1;
  localparam logic signed [IN_W:0] RND   = ({{IN_W{1'b0}}, 1'b1} << SHIFT) >> 1;
  localparam logic signed [IN_W:0] MAX_V = (IN_W + 1)'(MAX_I);
  localparam logic signed [IN_W:0] MIN_V = (IN_W + 1)'(-MAX_I - 1);

  state_t               state_q, state_d;
  logic [EW-1:0]        head_q, head_d, tail_q, tail_d;
  logic                 logic_en_q;
  logic                 tready_q, tready_d;
  logic                 sat_flag_q, sat_flag_d;
  logic [SAT_CNT_W-1:0] sat_count_q, sat_count_d;

  logic signed [IN_W:0] x_ext, r_sum, y_sh;
  logic                 sat_hi, sat_lo, sat_any;
  logic [OUT_W-1:0]     q_data;
  logic [EW-1:0]        new_entry;
  logic                 push, pop;

  always_comb begin
    x_ext   = {s_axis_tdata[IN_W-1], s_axis_tdata};
    r_sum   = x_ext + RND;
    y_sh    = r_sum >>> SHIFT;
    sat_hi  = (y_sh > MAX_V);
    sat_lo  = (y_sh < MIN_V);
    sat_any = sat_hi | sat_lo;
    if (sat_hi)      q_data = {1'b0, {(OUT_W - 1){1'b1}}};
    else if (sat_lo) q_data = {1'b1, {(OUT_W - 1){1'b0}}};
    else             q_data = y_sh[OUT_W-1:0];
    new_entry = {q_data, |s_axis_tkeep[3:2], |s_axis_tkeep[1:0], s_axis_tlast};
  end

  // Ready comes only from flops so the sink's tready never reaches the FIR combinationally.
  assign s_axis_tready = tready_q & logic_en_q;
  assign push          = s_axis_tvalid & s_axis_tready;
  assign m_axis_tvalid = (state_q != EMPTY);
  assign pop           = m_axis_tvalid & m_axis_tready;

  assign m_axis_tdata  = head_q[EW-1:3];
  assign m_axis_tkeep  = head_q[2:1];
  assign m_axis_tlast  = head_q[0];
  assign sat_flag      = sat_flag_q;
  assign sat_count     = sat_count_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (push) begin
          tail_d  = new_entry;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    tready_d = logic_en_q & (state_d != TWO);
  end

  // A saturating push in the same cycle as a clear restarts the stats at one event.
  always_comb begin
    sat_flag_d  = sat_flag_q;
    sat_count_d = sat_count_q;
    if (push && sat_any) begin
      sat_flag_d = 1'b1;
      if (sat_clear)         sat_count_d = SAT_CNT_W'(1);
      else if (!(&sat_count_q)) sat_count_d = sat_count_q + SAT_CNT_W'(1);
    end else if (sat_clear) begin
      sat_flag_d  = 1'b0;
      sat_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      logic_en_q  <= 1'b0;
      tready_q    <= 1'b0;
      sat_flag_q  <= 1'b0;
      sat_count_q <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      logic_en_q  <= power_enable;
      tready_q    <= tready_d;
      sat_flag_q  <= sat_flag_d;
      sat_count_q <= sat_count_d;
    end
  end

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed bench for fir_out_requant: rounding, saturation, skid backpressure, streaming,
// power-down drain, stats race and mid-stream reset.
module tb_fir_out_requant;

  logic        clk = 1'b0;
  logic        reset, power_enable;
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic        s_tlast, s_tvalid, s_tready;
  logic [15:0] m_tdata;
  logic [1:0]  m_tkeep;
  logic        m_tlast, m_tvalid, m_tready;
  logic        sat_clear, sat_flag;
  logic [15:0] sat_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fir_out_requant dut (
    .clk(clk), .reset(reset), .power_enable(power_enable),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .sat_clear(sat_clear), .sat_flag(sat_flag), .sat_count(sat_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; power_enable = 1'b1; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    s_tvalid = 1'b0; m_tready = 1'b0; sat_clear = 1'b0;
    repeat (3) tick();
    tests++;
    if ({s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, sat_flag, sat_count} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: tready=%b tvalid=%b data=%h keep=%b last=%b flag=%b cnt=%0d, all zero required",
               s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, sat_flag, sat_count);
    end
    reset = 1'b0;
    tick();
    tests++;
    if (s_tready !== 1'b0 || m_tvalid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_c1: tready=%b tvalid=%b, required 0 0", s_tready, m_tvalid);
    end
    tick();
    tests++;
    if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_c2: tready=%b tvalid=%b, required 1 0", s_tready, m_tvalid);
    end
  endtask

  task automatic test_rounding();
    logic [31:0] xv [4];
    logic [15:0] ev [4];
    logic [3:0]  kv [4];
    logic [1:0]  ek [4];
    xv = '{32'h0000_4000, 32'h0000_3FFF, 32'hFFFF_C000, 32'h3FFF_8000};
    ev = '{16'h0001, 16'h0000, 16'h0000, 16'h7FFF};
    kv = '{4'hF, 4'b0001, 4'b1000, 4'b0000};
    ek = '{2'b11, 2'b01, 2'b10, 2'b00};
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_tdata = xv[i]; s_tkeep = kv[i]; s_tlast = (i == 3); s_tvalid = 1'b1;
      tick();
      s_tvalid = 1'b0;
      tests++;
      if (m_tvalid !== 1'b1 || m_tdata !== ev[i] || m_tkeep !== ek[i] || m_tlast !== (i == 3)) begin
        fails++;
        $display("FAIL round_%0d: valid=%b data=%h keep=%b last=%b, required 1 %h %b %b",
                 i, m_tvalid, m_tdata, m_tkeep, m_tlast, ev[i], ek[i], (i == 3));
      end
      tick();
    end
    tests++;
    if (sat_flag !== 1'b0 || sat_count !== 16'd0) begin
      fails++;
      $display("FAIL round_no_sat: flag=%b cnt=%0d, required 0 0", sat_flag, sat_count);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] xv [2];
    logic [15:0] ev [2];
    xv = '{32'h4000_0000, 32'h8000_0000};
    ev = '{16'h7FFF, 16'h8000};
    m_tready = 1'b1; s_tkeep = 4'hF; s_tlast = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_tdata = xv[i]; s_tvalid = 1'b1;
      tick();
      s_tvalid = 1'b0;
      tests++;
      if (m_tvalid !== 1'b1 || m_tdata !== ev[i]) begin
        fails++;
        $display("FAIL sat_%0d: valid=%b data=%h, required 1 %h", i, m_tvalid, m_tdata, ev[i]);
      end
      tick();
    end
    tests++;
    if (sat_count !== 16'd2 || sat_flag !== 1'b1) begin
      fails++;
      $display("FAIL sat_stats: cnt=%0d flag=%b, required 2 1", sat_count, sat_flag);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] ev [3];
    int got;
    logic pushing;
    ev = '{16'h0001, 16'h0002, 16'h0003};
    m_tready = 1'b0; s_tkeep = 4'hF; s_tlast = 1'b0;
    s_tdata = 32'h0000_8000; s_tvalid = 1'b1;
    tick();
    s_tdata = 32'h0001_0000;
    tick();
    tests++;
    if (s_tready !== 1'b0 || m_tdata !== 16'h0001) begin
      fails++;
      $display("FAIL bp_full: tready=%b data=%h, required 0 0001", s_tready, m_tdata);
    end
    s_tdata = 32'h0001_8000;
    repeat (2) tick();
    tests++;
    if (s_tready !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== 16'h0001) begin
      fails++;
      $display("FAIL bp_stable: tready=%b valid=%b data=%h, required 0 1 0001", s_tready, m_tvalid, m_tdata);
    end
    m_tready = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && got < 3; c++) begin
      pushing = s_tvalid & s_tready;
      if (m_tvalid) begin
        tests++;
        if (m_tdata !== ev[got]) begin
          fails++;
          $display("FAIL bp_order_%0d: data=%h, required %h", got, m_tdata, ev[got]);
        end
        got++;
      end
      tick();
      if (pushing) s_tvalid = 1'b0;
    end
    tests++;
    if (got !== 3 || m_tvalid !== 1'b0 || s_tvalid !== 1'b0) begin
      fails++;
      $display("FAIL bp_count: beats=%0d valid_after=%b c_pending=%b, required 3 0 0", got, m_tvalid, s_tvalid);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic test_back_to_back();
    m_tready = 1'b1; s_tkeep = 4'hF;
    s_tdata = 32'(1) << 15; s_tlast = 1'b0; s_tvalid = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k <= 8) begin
        tests++;
        if (m_tvalid !== 1'b1 || m_tdata !== 16'(k) || m_tlast !== (k == 8) ||
            m_tkeep !== 2'b11 || s_tready !== 1'b1) begin
          fails++;
          $display("FAIL stream_%0d: valid=%b data=%h last=%b keep=%b tready=%b, required 1 %h %b 11 1",
                   k, m_tvalid, m_tdata, m_tlast, m_tkeep, s_tready, 16'(k), (k == 8));
        end
        if (k < 8) begin
          s_tdata = 32'(k + 1) << 15; s_tlast = (k + 1 == 8);
        end else begin
          s_tvalid = 1'b0; s_tlast = 1'b0;
        end
      end else begin
        tests++;
        if (m_tvalid !== 1'b0) begin
          fails++;
          $display("FAIL stream_drain: valid=%b, required 0", m_tvalid);
        end
      end
    end
  endtask

  task automatic test_powerdown();
    logic [15:0] ev [2];
    int got;
    ev = '{16'h0005, 16'h0006};
    m_tready = 1'b0; s_tkeep = 4'hF; s_tlast = 1'b0;
    s_tdata = 32'h0002_8000; s_tvalid = 1'b1;
    tick();
    s_tdata = 32'h0003_0000;
    tick();
    s_tvalid = 1'b0;
    power_enable = 1'b0;
    tick();
    tests++;
    if (s_tready !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== 16'h0005) begin
      fails++;
      $display("FAIL pd_hold: tready=%b valid=%b data=%h, required 0 1 0005", s_tready, m_tvalid, m_tdata);
    end
    m_tready = 1'b1;
    got = 0;
    for (int c = 0; c < 6 && got < 2; c++) begin
      if (m_tvalid) begin
        tests++;
        if (m_tdata !== ev[got]) begin
          fails++;
          $display("FAIL pd_drain_%0d: data=%h, required %h", got, m_tdata, ev[got]);
        end
        got++;
      end
      tick();
    end
    tests++;
    if (got !== 2 || s_tready !== 1'b0) begin
      fails++;
      $display("FAIL pd_drained: beats=%0d tready=%b, required 2 0", got, s_tready);
    end
    s_tdata = 32'h0003_8000; s_tvalid = 1'b1;
    repeat (2) tick();
    tests++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
      fails++;
      $display("FAIL pd_blocked: valid=%b tready=%b, required 0 0", m_tvalid, s_tready);
    end
    s_tvalid = 1'b0;
    power_enable = 1'b1;
    tick();
    tests++;
    if (s_tready !== 1'b0) begin
      fails++;
      $display("FAIL pd_wake_c1: tready=%b, required 0", s_tready);
    end
    tick();
    tests++;
    if (s_tready !== 1'b1) begin
      fails++;
      $display("FAIL pd_wake_c2: tready=%b, required 1", s_tready);
    end
  endtask

  task automatic test_stats_race();
    sat_clear = 1'b1;
    tick();
    sat_clear = 1'b0;
    tests++;
    if (sat_count !== 16'd0 || sat_flag !== 1'b0) begin
      fails++;
      $display("FAIL stats_clear: cnt=%0d flag=%b, required 0 0", sat_count, sat_flag);
    end
    m_tready = 1'b1; s_tkeep = 4'hF; s_tlast = 1'b0;
    s_tdata = 32'h4000_0000; s_tvalid = 1'b1;
    repeat (5) tick();
    s_tvalid = 1'b0;
    tests++;
    if (sat_count !== 16'd5 || sat_flag !== 1'b1) begin
      fails++;
      $display("FAIL stats_five: cnt=%0d flag=%b, required 5 1", sat_count, sat_flag);
    end
    tick();
    s_tdata = 32'h8000_0000; s_tvalid = 1'b1; sat_clear = 1'b1;
    tick();
    s_tvalid = 1'b0; sat_clear = 1'b0;
    tests++;
    if (sat_count !== 16'd1 || sat_flag !== 1'b1 || m_tdata !== 16'h8000) begin
      fails++;
      $display("FAIL stats_race: cnt=%0d flag=%b data=%h, required 1 1 8000", sat_count, sat_flag, m_tdata);
    end
    tick();
    sat_clear = 1'b1;
    tick();
    sat_clear = 1'b0;
    tests++;
    if (sat_count !== 16'd0 || sat_flag !== 1'b0) begin
      fails++;
      $display("FAIL stats_clear2: cnt=%0d flag=%b, required 0 0", sat_count, sat_flag);
    end
  endtask

  task automatic test_reset_midstream();
    m_tready = 1'b0; s_tkeep = 4'hF; s_tlast = 1'b1;
    s_tdata = 32'h0000_8000; s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
    reset = 1'b1;
    tick();
    tests++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b0 || m_tlast !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid: valid=%b tready=%b last=%b, required 0 0 0", m_tvalid, s_tready, m_tlast);
    end
    reset = 1'b0;
    repeat (2) tick();
    tests++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_recover: valid=%b tready=%b, required 0 1", m_tvalid, s_tready);
    end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_powerdown();
    test_stats_race();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
